// File: rtl/noc_packet_checker.sv
// noc_packet_checker
//   Receive-side scoring endpoint for NoC test traffic. It sinks flits from a
//   router eject port and checks each packet for three things: the header
//   destination must be this node, every body or tail flit k must equal the
//   header flit + k (mod 2^Noc_Data_Width), and the framing must be legal.
//   Good and bad packets are counted with saturating counters.
//
//   Header layout (LSB up): dest_x, dest_y, src_x, src_y.
//   A packet may hold at most MAX_LEN flits, counting the header and the tail.
//   A non-tail flit at index MAX_LEN-1 is a length error. A packet of exactly
//   MAX_LEN flits is legal.
//
//   Optional feature macro: NOC_CHECKER_BACKPRESSURE_EN
//     defined   : an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) throttles
//                 receive_ready, which is registered as ~lfsr[0].
//     undefined : receive_ready is held high after reset.
//
// Ports
//   noc_clk, noc_rst_n     clock, asynchronous active-low reset
//   clear                  synchronous clear of counters/status, FSM to IDLE
//   receive_valid/ready    flit handshake with the router
//   receive_flit           flit data
//   receive_is_header/tail framing marks
//   pkt_count, err_count   good / bad packet counters (saturating)
//   err_code               sticky code of most recent error
//                          (1 DEST, 2 FRAME, 3 DATA, 4 LEN)
//   err_pulse              one-cycle pulse per detected error
//   last_src_x/y           source of the last good packet
//   busy                   packet in progress (FSM not IDLE)

`ifndef Noc_Data_Width
`define Noc_Data_Width 16
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif

module noc_packet_checker #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID    = {`Noc_ID_X_Width{1'b0}},
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID    = {`Noc_ID_Y_Width{1'b0}},
    parameter int unsigned                MAX_LEN = 16,
    parameter int unsigned                CNT_W   = 16
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic                       clear,
    input  logic                       receive_valid,
    output logic                       receive_ready,
    input  logic [`Noc_Data_Width-1:0] receive_flit,
    input  logic                       receive_is_header,
    input  logic                       receive_is_tail,
    output logic [CNT_W-1:0]           pkt_count,
    output logic [CNT_W-1:0]           err_count,
    output logic [2:0]                 err_code,
    output logic                       err_pulse,
    output logic [`Noc_ID_X_Width-1:0] last_src_x,
    output logic [`Noc_ID_Y_Width-1:0] last_src_y,
    output logic                       busy
);
    localparam int unsigned DW = `Noc_Data_Width;
    localparam int unsigned XW = `Noc_ID_X_Width;
    localparam int unsigned YW = `Noc_ID_Y_Width;
    localparam int unsigned KW = $clog2(MAX_LEN);
    localparam logic [KW-1:0] K_LAST = KW'(MAX_LEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BODY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [2:0] ERR_DEST  = 3'd1;
    localparam logic [2:0] ERR_FRAME = 3'd2;
    localparam logic [2:0] ERR_DATA  = 3'd3;
    localparam logic [2:0] ERR_LEN   = 3'd4;

    // Saturating add: the result sticks at all-ones and never wraps.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, v} + (CNT_W+1)'(inc);
        if (sum[CNT_W]) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    logic [1:0]       state_d, state_q;
    logic [DW-1:0]    hdr_d, hdr_q;
    logic [KW-1:0]    k_d, k_q;
    logic [CNT_W-1:0] pkt_count_d, pkt_count_q, err_count_d, err_count_q;
    logic [2:0]       err_code_d, err_code_q;
    logic             err_pulse_d, err_pulse_q, busy_d, busy_q, ready_d, ready_q;
    logic [XW-1:0]    last_src_x_d, last_src_x_q;
    logic [YW-1:0]    last_src_y_d, last_src_y_q;

    logic          xfer_s, fresh_s, good_s, err_a_s, err_b_s, dest_ok_s;
    logic [2:0]    code_a_s, code_b_s;
    logic [DW-1:0] expect_s;
    logic [XW-1:0] good_sx_s;
    logic [YW-1:0] good_sy_s;

    assign xfer_s    = receive_valid & ready_q;
    assign expect_s  = hdr_q + DW'(k_q);
    assign dest_ok_s = (receive_flit[XW-1:0] == X_ID) && (receive_flit[XW +: YW] == Y_ID);

    // Packet FSM, scoring and counter next-state.
    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        k_d          = k_q;
        pkt_count_d  = pkt_count_q;
        err_count_d  = err_count_q;
        err_code_d   = err_code_q;
        err_pulse_d  = 1'b0;
        last_src_x_d = last_src_x_q;
        last_src_y_d = last_src_y_q;
        fresh_s      = 1'b0;
        good_s       = 1'b0;
        err_a_s      = 1'b0;
        code_a_s     = 3'd0;
        err_b_s      = 1'b0;
        code_b_s     = 3'd0;
        good_sx_s    = hdr_q[XW+YW +: XW];
        good_sy_s    = hdr_q[2*XW+YW +: YW];
        if (clear) begin
            // A flit transferred in the same cycle is accepted but ignored.
            state_d      = ST_IDLE;
            hdr_d        = {DW{1'b0}};
            k_d          = {KW{1'b0}};
            pkt_count_d  = {CNT_W{1'b0}};
            err_count_d  = {CNT_W{1'b0}};
            err_code_d   = 3'd0;
            last_src_x_d = {XW{1'b0}};
            last_src_y_d = {YW{1'b0}};
        end else if (xfer_s) begin
            // Error "a" scores the packet in progress; error "b" scores the
            // flit treated as a fresh packet start. A header that cuts a
            // packet short can therefore raise both in one cycle.
            case (state_q)
                ST_IDLE: begin
                    fresh_s = 1'b1;
                end
                ST_BODY: begin
                    if (receive_is_header) begin
                        err_a_s  = 1'b1;
                        code_a_s = ERR_FRAME;
                        fresh_s  = 1'b1;
                    end else if (receive_flit != expect_s) begin
                        err_a_s  = 1'b1;
                        code_a_s = ERR_DATA;
                        state_d  = receive_is_tail ? ST_IDLE : ST_DRAIN;
                    end else if (receive_is_tail) begin
                        good_s  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (k_q == K_LAST) begin
                        err_a_s  = 1'b1;
                        code_a_s = ERR_LEN;
                        state_d  = ST_DRAIN;
                    end else begin
                        k_d = k_q + KW'(1'b1);
                    end
                end
                ST_DRAIN: begin
                    if (receive_is_header) begin
                        err_a_s  = 1'b1;
                        code_a_s = ERR_FRAME;
                        fresh_s  = 1'b1;
                    end else if (receive_is_tail) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (fresh_s) begin
                if (!receive_is_header) begin
                    err_b_s  = 1'b1;
                    code_b_s = ERR_FRAME;
                    state_d  = receive_is_tail ? ST_IDLE : ST_DRAIN;
                end else if (!dest_ok_s) begin
                    err_b_s  = 1'b1;
                    code_b_s = ERR_DEST;
                    state_d  = receive_is_tail ? ST_IDLE : ST_DRAIN;
                end else if (receive_is_tail) begin
                    good_s    = 1'b1;
                    good_sx_s = receive_flit[XW+YW +: XW];
                    good_sy_s = receive_flit[2*XW+YW +: YW];
                    state_d   = ST_IDLE;
                end else begin
                    hdr_d   = receive_flit;
                    k_d     = KW'(1'b1);
                    state_d = ST_BODY;
                end
            end else begin
                hdr_d = hdr_q;
            end
            pkt_count_d  = good_s ? sat_add(pkt_count_q, 2'd1) : pkt_count_q;
            err_count_d  = sat_add(err_count_q, {1'b0, err_a_s} + {1'b0, err_b_s});
            err_code_d   = err_b_s ? code_b_s : (err_a_s ? code_a_s : err_code_q);
            err_pulse_d  = err_a_s | err_b_s;
            last_src_x_d = good_s ? good_sx_s : last_src_x_q;
            last_src_y_d = good_s ? good_sy_s : last_src_y_q;
        end else begin
            err_pulse_d = 1'b0;
        end
    end

    assign busy_d = (state_d != ST_IDLE);

`ifdef NOC_CHECKER_BACKPRESSURE_EN
    logic [7:0] lfsr_d, lfsr_q;

    // Pseudo-random throttle; the ready flag lags the LFSR by one register.
    always_comb begin
        if (clear) begin
            lfsr_d  = 8'hA5;
            ready_d = 1'b1;
        end else begin
            lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            ready_d = ~lfsr_q[0];
        end
    end

    // LFSR state register.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign ready_d = 1'b1;
`endif

    // State, counter and output registers.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q      <= ST_IDLE;
            hdr_q        <= {DW{1'b0}};
            k_q          <= {KW{1'b0}};
            pkt_count_q  <= {CNT_W{1'b0}};
            err_count_q  <= {CNT_W{1'b0}};
            err_code_q   <= 3'd0;
            err_pulse_q  <= 1'b0;
            last_src_x_q <= {XW{1'b0}};
            last_src_y_q <= {YW{1'b0}};
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            k_q          <= k_d;
            pkt_count_q  <= pkt_count_d;
            err_count_q  <= err_count_d;
            err_code_q   <= err_code_d;
            err_pulse_q  <= err_pulse_d;
            last_src_x_q <= last_src_x_d;
            last_src_y_q <= last_src_y_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    assign receive_ready = ready_q;
    assign pkt_count     = pkt_count_q;
    assign err_count     = err_count_q;
    assign err_code      = err_code_q;
    assign err_pulse     = err_pulse_q;
    assign last_src_x    = last_src_x_q;
    assign last_src_y    = last_src_y_q;
    assign busy          = busy_q;

endmodule
